// File: rtl/button_click_decoder_pkg.sv
// button_click_decoder_pkg: shared FSM encoding, default timing and timer sizing
package button_click_decoder_pkg;
  typedef enum logic [2:0] {IDLE, PRESS1, LONG_HELD, GAP, PRESS2} state_t;
  localparam int DEF_DEBOUNCE_CYC = 16;
  localparam int DEF_LONG_CYC = 1000;
  localparam int DEF_GAP_CYC = 250;
  function automatic int timer_bits(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/button_click_decoder_debouncer.sv
// button_debouncer: 2-flop synchronizer followed by a consecutive-stability debouncer
module button_debouncer import button_click_decoder_pkg::*; #(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  // synchronize, then accept a new level only after DEBOUNCE_CYC mismatching cycles in a row
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      o_level <= 1'b0;
    end else begin
      s1 <= i_raw;
      s2 <= s1;
      if (s2 == o_level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        o_level <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/button_click_decoder.sv
// button_click_decoder: classifies debounced presses into single, double and long clicks
module button_click_decoder import button_click_decoder_pkg::*; #(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push_button,
  output logic o_single,
  output logic o_double,
  output logic o_long,
  output logic o_busy
);
  localparam int TW = timer_bits(LONG_CYC, GAP_CYC);
  logic level, level_q, rise, fall;
  logic single_nxt, double_nxt, long_nxt;
  logic [TW-1:0] timer;
  state_t state, state_nxt;
  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debouncer (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_raw(i_push_button),
    .o_level(level)
  );
  assign rise = level & ~level_q;
  assign fall = ~level & level_q;
  // gesture classification; a pending gap expiry outranks a simultaneous new press
  always_comb begin
    state_nxt = state;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt = 1'b0;
    unique case (state)
      IDLE: state_nxt = rise ? PRESS1 : IDLE;
      PRESS1:
        if (fall) state_nxt = GAP;
        else if (timer == TW'(LONG_CYC - 1)) begin
          state_nxt = LONG_HELD;
          long_nxt = 1'b1;
        end
      LONG_HELD: state_nxt = fall ? IDLE : LONG_HELD;
      GAP:
        if (timer == TW'(GAP_CYC - 1)) begin
          state_nxt = IDLE;
          single_nxt = 1'b1;
        end else if (rise) state_nxt = PRESS2;
      PRESS2:
        if (fall) begin
          state_nxt = IDLE;
          double_nxt = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end
  // state, saturating shared timer cleared on every transition, edge history and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      timer <= '0;
      level_q <= 1'b0;
      o_single <= 1'b0;
      o_double <= 1'b0;
      o_long <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state) ? '0 : (&timer ? timer : timer + 1'b1);
      level_q <= level;
      o_single <= single_nxt;
      o_double <= double_nxt;
      o_long <= long_nxt;
      o_busy <= state_nxt != IDLE;
    end
endmodule
